gate_truth_table_checker: RTL and testbench

GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

---
 rtl/gate_test_pkg.sv | 38 +++
 rtl/gate_ref_model.sv | 35 +++
 rtl/gate_truth_table_checker.sv | 183 ++++++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
//
// Shared definitions for the 2-input gate truth-table checker:
//   - NUM_VECTORS : number of {a,b} input combinations exercised (4)
//   - gate_op_e   : encoding of the gate under test on the 3-bit op input
//   - state_e     : checker FSM state encoding
//   - op_is_valid : true for the six defined gate encodings
// -----------------------------------------------------------------------------
package gate_test_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = $clog2(NUM_VECTORS);
  localparam int OP_W        = 3;
  localparam int WAIT_W      = 4;   // holds SETTLE up to 15

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Encodings 6 and 7 are unassigned and are reported as an operator error.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
//
// Combinational golden model of the gate under test. Produces the value the
// external gate should output for the given operator and inputs.
//
// Ports:
//   op     in  3  gate encoding (gate_op_e); invalid encodings give 0
//   a      in  1  gate input a
//   b      in  1  gate input b
//   y_exp  out 1  expected gate output
// -----------------------------------------------------------------------------
module gate_ref_model
  import gate_test_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (op)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
//
// Walks an external 2-input gate through all four {a,b} vectors, holding each
// for SETTLE cycles before sampling the gate output, and reports which vectors
// disagree with the selected gate function.
//
// Parameters:
//   SETTLE     1..15  cycles each vector is held before y_in is sampled
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  run request, honoured only in IDLE
//   op         in   3  gate under test, latched when start is accepted
//   a_out      out  1  external gate input a
//   b_out      out  1  external gate input b
//   y_in       in   1  external gate output (combinational from a_out/b_out)
//   busy       out  1  test in progress
//   done       out  1  one-cycle completion pulse
//   pass       out  1  all vectors matched and op valid; valid from done
//   fail_mask  out  4  bit i set when vector {a,b}=i mismatched
//   op_err     out  1  latched op was an unassigned encoding
// -----------------------------------------------------------------------------
module gate_truth_table_checker
  import gate_test_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OP_W-1:0]        op,
  output logic                   a_out,
  output logic                   b_out,
  input  logic                   y_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_mask,
  output logic                   op_err
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VECTORS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [OP_W-1:0]          op_q, op_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [NUM_VECTORS-1:0]   fail_mask_q, fail_mask_d;
  logic                     op_err_q, op_err_d;
  logic                     pass_q, pass_d;
  logic                     done_c;
  logic                     drive_vec;
  logic                     y_exp;

  // ---------------------------------------------------------------------------
  // Expected gate output for the current vector
  // ---------------------------------------------------------------------------
  gate_ref_model u_ref (
    .op    (op_q),
    .a     (idx_q[1]),
    .b     (idx_q[0]),
    .y_exp (y_exp)
  );

  // ---------------------------------------------------------------------------
  // Register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      fail_mask_q <= '0;
      op_err_q    <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      fail_mask_q <= fail_mask_d;
      op_err_q    <= op_err_d;
      pass_q      <= pass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    fail_mask_d = fail_mask_q;
    op_err_d    = op_err_q;
    pass_d      = pass_q;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d        = op;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          idx_d       = '0;
          wait_d      = '0;
          if (op_is_valid(op)) begin
            op_err_d = 1'b0;
            state_d  = ST_DRIVE;
          end else begin
            op_err_d = 1'b1;
            state_d  = ST_FINISH;
          end
        end
      end

      ST_DRIVE: begin
        // The vector has been on the pins for SETTLE cycles once the counter
        // reaches SETTLE-1; the following cycle samples it.
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (y_in != y_exp) begin
          fail_mask_d[idx_q] = 1'b1;
        end
        wait_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_FINISH: begin
        // An invalid op jumps here straight from IDLE; it dwells one extra
        // cycle (tracked on the otherwise idle wait counter) so its done pulse
        // lands two cycles after start. Valid runs report immediately.
        if (op_err_q && (wait_q == '0)) begin
          wait_d = wait_q + 1'b1;
        end else begin
          done_c  = 1'b1;
          pass_d  = (fail_mask_q == '0) && !op_err_q;
          idx_d   = '0;
          wait_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign drive_vec = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  assign a_out     = drive_vec & idx_q[1];
  assign b_out     = drive_vec & idx_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_c;
  // The verdict is visible in the done cycle itself and held afterwards.
  assign pass      = done_c ? pass_d : pass_q;
  assign fail_mask = fail_mask_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_table_checker
//
// Two checkers (SETTLE=1 and SETTLE=3) share start/op/rst; each drives its own
// model of an external gate described by a 4-entry truth table. Expected
// outcomes come from truth-table arithmetic and simple latency formulas.
// -----------------------------------------------------------------------------
module tb_gate_truth_table_checker;

  localparam int S0 = 1;
  localparam int S1 = 3;
  localparam int NCYC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;

  logic a0, b0, y0, busy0, done0, pass0, operr0;
  logic a1, b1, y1, busy1, done1, pass1, operr1;
  logic [3:0] fm0, fm1;

  // Truth tables: bit v is the gate output for {a,b} = v.
  logic [3:0] tt [0:5];
  logic [3:0] ext_tt;

  int checks = 0;
  int errors = 0;

  assign y0 = ext_tt[{a0, b0}];
  assign y1 = ext_tt[{a1, b1}];

  always #5 clk = ~clk;

  gate_truth_table_checker #(.SETTLE(S0)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_out(a0), .b_out(b0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fm0), .op_err(operr0)
  );

  gate_truth_table_checker #(.SETTLE(S1)) dut_s3 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .op_err(operr1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, a, b} expected k cycles after the start cycle.
  function automatic logic [3:0] exp_obs(input int k, input int lat, input int s, input bit valid);
    int vec;
    if (k < lat) begin
      vec = valid ? (k - 1) / (s + 1) : 0;
      return {2'b10, 2'(vec)};
    end else if (k == lat) begin
      return 4'b1100;
    end
    return 4'b0000;
  endfunction

  task automatic check_inst(input string name, input int k, input int lat, input int s,
                            input bit valid, input logic [3:0] obs,
                            input logic pass_v, input logic [3:0] fm_v, input logic operr_v,
                            input logic [3:0] exp_mask, input bit exp_pass);
    check_eq($sformatf("%s k%0d busy/done/ab", name, k), 32'(obs), 32'(exp_obs(k, lat, s, valid)));
    if (k == lat || k == NCYC) begin
      check_eq($sformatf("%s k%0d pass", name, k), 32'(pass_v), 32'(exp_pass));
      check_eq($sformatf("%s k%0d fail_mask", name, k), 32'(fm_v), 32'(exp_mask));
      check_eq($sformatf("%s k%0d op_err", name, k), 32'(operr_v), 32'(!valid));
    end
  endtask

  // One test run on both checkers. With disturb set, start is pulsed and op
  // is scrambled while both are busy (including the done cycle), which must
  // change nothing.
  task automatic run_txn(input int n, input int top_op, input int kind, input bit disturb);
    bit         valid;
    logic [3:0] exp_mask;
    bit         exp_pass;
    int         lat0, lat1, win;
    valid    = (top_op <= 5);
    ext_tt   = tt[kind];
    exp_mask = valid ? (tt[top_op] ^ ext_tt) : 4'b0000;
    exp_pass = valid && (exp_mask == 4'b0000);
    lat0     = valid ? 1 + 4 * (S0 + 1) : 2;
    lat1     = valid ? 1 + 4 * (S1 + 1) : 2;
    win      = valid ? lat0 : 2;

    op    = 3'(top_op);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= NCYC; k++) begin
      check_inst("s1", k, lat0, S0, valid, {busy0, done0, a0, b0}, pass0, fm0, operr0, exp_mask, exp_pass);
      check_inst("s3", k, lat1, S1, valid, {busy1, done1, a1, b1}, pass1, fm1, operr1, exp_mask, exp_pass);
      if (disturb) begin
        op    = 3'($urandom_range(0, 7));
        start = (k <= win) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("txn %0d op=%0d gate=%0d disturb=%0d exp_mask=%b exp_pass=%0d got s1=%b/%0d s3=%b/%0d",
             n, top_op, kind, disturb, exp_mask, exp_pass, fm0, pass0, fm1, pass1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " s1 outputs"}, 32'({busy0, done0, a0, b0, pass0, fm0, operr0}), 32'(0));
    check_eq({tag, " s3 outputs"}, 32'({busy1, done1, a1, b1, pass1, fm1, operr1}), 32'(0));
  endtask

  initial begin
    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0111;  // NAND
    tt[3] = 4'b0001;  // NOR
    tt[4] = 4'b0110;  // XOR
    tt[5] = 4'b1001;  // XNOR
    ext_tt = tt[0];
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed: AND gate tested as AND, as XOR, and with an invalid op.
    run_txn(0, 0, 0, 1'b0);
    run_txn(1, 4, 0, 1'b0);
    run_txn(2, 7, 0, 1'b0);

    // Reset while vector 2 is on the pins of the SETTLE=1 checker.
    ext_tt = tt[0];
    op     = 3'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) check_eq("pre-reset s1 vector", 32'({busy0, a0, b0}), 32'(3'b110));
      if (k == 5) rst = 1'b1;
      @(negedge clk);
    end
    check_all_zero("mid-test reset");
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done0 || done1 || busy0 || busy1) begin
        check_eq($sformatf("post-reset idle k%0d", k), 32'({done0, done1, busy0, busy1}), 32'(0));
      end
      @(negedge clk);
    end
    check_eq("post-reset quiet", 32'({done0, done1, busy0, busy1}), 32'(0));
    run_txn(3, 0, 0, 1'b0);

    // Randomized runs with mid-test start pulses and op changes.
    for (int n = 4; n < 34; n++) begin
      run_txn(n, int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
